// File: rtl/mem_pkg.sv
// Shared types and default geometry for the memory port arbiter and the memory it drives.
package mem_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_DEPTH  = 256;

    // Indices into the per-port read-return arrays.
    localparam int PORT_IF = 0;
    localparam int PORT_DM = 1;

    typedef enum logic {
        S_LOAD,
        S_RUN
    } state_e;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_IF,
        TAG_DM
    } rd_tag_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the loader stream, fetch port, data port and memory bus of the arbiter.
interface mem_port_arbiter_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
);
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              load_done;
    logic [ADDR_W:0]   load_count;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  ld_valid, ld_data, ld_last,
        output ld_ready, load_done, load_count,
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester / memory side.
    modport master (
        output ld_valid, ld_data, ld_last,
        input  ld_ready, load_done, load_count,
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_boot_loader.sv
// Boot-load sequencer: writes the incoming word stream to addresses 0.. and owns the LOAD/RUN state.
module mem_boot_loader
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DEPTH  = MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    output logic              load_done_o,
    output logic [ADDR_W:0]   load_count_o,
    output state_e            state_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o
);

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] COUNT_ONE = (ADDR_W + 1)'(1);

    state_e          state_q;
    logic            ld_ready_q;
    logic            done_q;
    logic [ADDR_W:0] count_q;
    logic            accept;

    // ld_ready_q is only ever set while in S_LOAD, so it alone qualifies a write.
    assign accept = ld_valid_i && ld_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOAD;
            ld_ready_q <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    ld_ready_q <= 1'b1;
                    if (accept) begin
                        count_q <= count_q + COUNT_ONE;
                        if (ld_last_i || (count_q == LAST_ADDR)) begin
                            state_q    <= S_RUN;
                            ld_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    ld_ready_q <= 1'b0;
                    done_q     <= 1'b1;
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    assign ld_ready_o   = ld_ready_q;
    assign load_done_o  = done_q;
    assign load_count_o = count_q;
    assign state_o      = state_q;
    assign wr_en_o      = accept;
    assign wr_addr_o    = count_q[ADDR_W-1:0];

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory owner: boot-loads the image, then arbitrates fetch vs data access one per cycle.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int DEPTH      = MEM_DEPTH,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam int SW = ($clog2(STARVE_MAX + 1) > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);

    state_e            state;
    logic              loader_wr;
    logic [ADDR_W-1:0] loader_addr;
    logic              load_wr;
    logic              run;
    logic              starved;
    logic              if_gnt;
    logic              dm_gnt;
    logic [SW-1:0]     starve_q, starve_d;
    rd_tag_e           tag_q, tag_d;
    logic [1:0]        rvalid;
    logic [DATA_W-1:0] rdata [2];

    mem_boot_loader #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_loader (
        .clk          (clk),
        .rst          (rst),
        .ld_valid_i   (bus.ld_valid),
        .ld_last_i    (bus.ld_last),
        .ld_ready_o   (bus.ld_ready),
        .load_done_o  (bus.load_done),
        .load_count_o (bus.load_count),
        .state_o      (state),
        .wr_en_o      (loader_wr),
        .wr_addr_o    (loader_addr)
    );

    // Nothing touches memory while reset is held, so a mid-run reset leaves contents intact.
    assign load_wr = loader_wr && !rst;
    assign run     = (state == S_RUN) && !rst;
    assign starved = (starve_q == STARVE_LIM);

    assign if_gnt = run && bus.if_req && (!bus.dm_req || starved);
    assign dm_gnt = run && bus.dm_req && !if_gnt;

    always_comb begin
        starve_d = starve_q;
        if (!run || !bus.if_req || if_gnt) begin
            starve_d = '0;
        end else if (!starved) begin
            starve_d = starve_q + STARVE_ONE;
        end
    end

    always_comb begin
        tag_d = TAG_NONE;
        if (if_gnt) begin
            tag_d = TAG_IF;
        end else if (dm_gnt && !bus.dm_we) begin
            tag_d = TAG_DM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            tag_q    <= TAG_NONE;
        end else begin
            starve_q <= starve_d;
            tag_q    <= tag_d;
        end
    end

    // A reset arriving in the return cycle cancels the pending read.
    assign rvalid[PORT_IF] = (tag_q == TAG_IF) && !rst;
    assign rvalid[PORT_DM] = (tag_q == TAG_DM) && !rst;

    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
        logic [DATA_W-1:0] hold_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                hold_q <= '0;
            end else if (rvalid[gi]) begin
                hold_q <= bus.mem_rdata;
            end
        end

        assign rdata[gi] = rvalid[gi] ? bus.mem_rdata : hold_q;
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.dm_gnt    = dm_gnt;
    assign bus.if_rvalid = rvalid[PORT_IF];
    assign bus.dm_rvalid = rvalid[PORT_DM];
    assign bus.if_rdata  = rdata[PORT_IF];
    assign bus.dm_rdata  = rdata[PORT_DM];

    assign bus.mem_en    = load_wr || if_gnt || dm_gnt;
    assign bus.mem_we    = load_wr || (dm_gnt && bus.dm_we);
    assign bus.mem_addr  = load_wr ? loader_addr :
                           if_gnt  ? bus.if_addr : bus.dm_addr;
    assign bus.mem_wdata = load_wr ? bus.ld_data : bus.dm_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: vector table for arbitration, scoreboard for read returns, directed corner cases.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst4 = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();
    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) b4 ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .STARVE_MAX(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .DEPTH(4), .STARVE_MAX(4)) u_dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (b4)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Memory behind the main arbiter, registered read.
    logic [31:0] tb_mem [256];
    logic [31:0] ref_mem [256];
    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = 32'h0;
            ref_mem[i] = 32'h0;
        end
        bus.mem_rdata = 32'h0;
        b4.mem_rdata  = 32'h0;
    end

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) tb_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            else            bus.mem_rdata <= tb_mem[bus.mem_addr[7:0]];
        end
    end

    int w4_cnt = 0;
    always @(posedge clk) if (!rst4 && b4.mem_en && b4.mem_we) w4_cnt++;

    // Read scoreboard: expectation queued on the request cycle, consumed one cycle later.
    typedef struct {
        bit          is_dm;
        logic [31:0] data;
    } rd_t;
    rd_t sb_q[$];
    bit  mon_en = 1'b0;

    always @(negedge clk) begin : mon
        rd_t         e;
        logic        e_if, e_dm;
        logic [31:0] e_data;
        if (mon_en) begin
            e_if = 1'b0; e_dm = 1'b0; e_data = 32'h0;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (!rst) begin
                    e_if = !e.is_dm; e_dm = e.is_dm; e_data = e.data;
                end
            end
            chk("sb_if_rvalid", bus.if_rvalid, e_if);
            chk("sb_dm_rvalid", bus.dm_rvalid, e_dm);
            if (e_if) chk("sb_if_rdata", bus.if_rdata, e_data);
            if (e_dm) chk("sb_dm_rdata", bus.dm_rdata, e_data);
            if (bus.if_gnt) sb_q.push_back('{1'b0, ref_mem[bus.if_addr[7:0]]});
            if (bus.dm_gnt && !bus.dm_we) sb_q.push_back('{1'b1, ref_mem[bus.dm_addr[7:0]]});
            if (bus.dm_gnt && bus.dm_we) ref_mem[bus.dm_addr[7:0]] = bus.dm_wdata;
        end
    end

    typedef struct {
        logic        if_req, dm_req, dm_we;
        logic [15:0] if_addr, dm_addr;
        logic [31:0] dm_wdata;
        logic        e_if_gnt, e_dm_gnt, e_mem_en, e_mem_we;
        logic [15:0] e_mem_addr;
    } vec_t;
    vec_t vt [7];

    task automatic idle();
        bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        vt[0] = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vt[1] = '{1'b1, 1'b0, 1'b0, 16'd3, 16'd0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 16'd3};
        vt[2] = '{1'b0, 1'b1, 1'b0, 16'd0, 16'd1, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
        vt[3] = '{1'b1, 1'b1, 1'b0, 16'd2, 16'd0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
        vt[4] = '{1'b0, 1'b1, 1'b1, 16'd0, 16'd7, 32'hA5A55A5A,  1'b0, 1'b1, 1'b1, 1'b1, 16'd7};
        vt[5] = '{1'b1, 1'b1, 1'b1, 16'd1, 16'd8, 32'h0BADF00D,  1'b0, 1'b1, 1'b1, 1'b1, 16'd8};
        vt[6] = '{1'b0, 1'b1, 1'b0, 16'd0, 16'd7, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 16'd7};

        idle();
        bus.ld_data = 32'h0; bus.if_addr = 16'h0; bus.dm_addr = 16'h0; bus.dm_wdata = 32'h0;
        b4.ld_valid = 1'b0; b4.ld_last = 1'b0; b4.ld_data = 32'h0;
        b4.if_req = 1'b0; b4.if_addr = 16'h0; b4.dm_req = 1'b0; b4.dm_we = 1'b0;
        b4.dm_addr = 16'h0; b4.dm_wdata = 32'h0;

        // Reset state
        step(); rst = 1'b0;
        @(negedge clk);
        chk("rst_ld_ready", bus.ld_ready, 1'b0);
        chk("rst_load_done", bus.load_done, 1'b0);
        chk("rst_load_count", bus.load_count, 17'd0);
        chk("rst_if_gnt", bus.if_gnt, 1'b0);
        chk("rst_dm_gnt", bus.dm_gnt, 1'b0);
        chk("rst_if_rvalid", bus.if_rvalid, 1'b0);
        chk("rst_dm_rvalid", bus.dm_rvalid, 1'b0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_dm_rdata", bus.dm_rdata, 32'h0);
        chk("rst_mem_en", bus.mem_en, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        mon_en = 1'b1;

        // Boot load of four words, fetch held pending throughout
        for (int i = 0; i < 4; i++) begin
            step();
            bus.ld_valid = 1'b1; bus.ld_data = 32'hDEAD0000 + 32'(i); bus.ld_last = (i == 3);
            bus.if_req = 1'b1; bus.if_addr = 16'd2;
            ref_mem[i] = 32'hDEAD0000 + 32'(i);
            @(negedge clk);
            $display("load word %0d addr=%0h data=%0h", i, bus.mem_addr, bus.mem_wdata);
            chk("load_ready", bus.ld_ready, 1'b1);
            chk("load_mem_en", bus.mem_en, 1'b1);
            chk("load_mem_we", bus.mem_we, 1'b1);
            chk("load_mem_addr", bus.mem_addr, 16'(i));
            chk("load_mem_wdata", bus.mem_wdata, 32'hDEAD0000 + 32'(i));
            chk("load_count_run", bus.load_count, 17'(i));
            chk("load_done_early", bus.load_done, 1'b0);
            chk("load_if_gnt", bus.if_gnt, 1'b0);
        end
        step();
        bus.ld_valid = 1'b1; bus.ld_last = 1'b0; bus.ld_data = 32'hBAADBAAD; bus.if_req = 1'b0;
        @(negedge clk);
        chk("post_load_done", bus.load_done, 1'b1);
        chk("post_load_count", bus.load_count, 17'd4);
        chk("post_ld_ready", bus.ld_ready, 1'b0);
        chk("post_ld_ignored", bus.mem_en, 1'b0);
        step(); idle();
        @(negedge clk);

        // Arbitration table, idle cycle between vectors so starvation state is clear
        for (int v = 0; v < 7; v++) begin
            step();
            bus.if_req = vt[v].if_req; bus.dm_req = vt[v].dm_req; bus.dm_we = vt[v].dm_we;
            bus.if_addr = vt[v].if_addr; bus.dm_addr = vt[v].dm_addr; bus.dm_wdata = vt[v].dm_wdata;
            @(negedge clk);
            $display("vec %0d if_gnt=%0b dm_gnt=%0b mem_en=%0b mem_we=%0b addr=%0h",
                     v, bus.if_gnt, bus.dm_gnt, bus.mem_en, bus.mem_we, bus.mem_addr);
            chk("vec_if_gnt", bus.if_gnt, vt[v].e_if_gnt);
            chk("vec_dm_gnt", bus.dm_gnt, vt[v].e_dm_gnt);
            chk("vec_mem_en", bus.mem_en, vt[v].e_mem_en);
            chk("vec_mem_we", bus.mem_we, vt[v].e_mem_we);
            if (vt[v].e_mem_en) chk("vec_mem_addr", bus.mem_addr, vt[v].e_mem_addr);
            if (vt[v].e_mem_we) chk("vec_mem_wdata", bus.mem_wdata, vt[v].dm_wdata);
            step(); idle();
            @(negedge clk);
        end

        // Priority plus read return
        step();
        bus.if_req = 1'b1; bus.if_addr = 16'd1;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'd2;
        @(negedge clk);
        chk("prio_dm_gnt", bus.dm_gnt, 1'b1);
        chk("prio_if_gnt", bus.if_gnt, 1'b0);
        chk("prio_mem_addr", bus.mem_addr, 16'd2);
        step(); bus.dm_req = 1'b0;
        @(negedge clk);
        $display("prio dm_rvalid=%0b dm_rdata=%0h if_gnt=%0b", bus.dm_rvalid, bus.dm_rdata, bus.if_gnt);
        chk("prio_dm_rvalid", bus.dm_rvalid, 1'b1);
        chk("prio_dm_rdata", bus.dm_rdata, 32'hDEAD0002);
        chk("prio_if_gnt2", bus.if_gnt, 1'b1);
        chk("prio_mem_addr2", bus.mem_addr, 16'd1);
        step(); bus.if_req = 1'b0;
        @(negedge clk);
        $display("prio if_rvalid=%0b if_rdata=%0h", bus.if_rvalid, bus.if_rdata);
        chk("prio_if_rvalid", bus.if_rvalid, 1'b1);
        chk("prio_if_rdata", bus.if_rdata, 32'hDEAD0001);
        chk("prio_dm_rvalid_off", bus.dm_rvalid, 1'b0);
        chk("prio_dm_rdata_hold", bus.dm_rdata, 32'hDEAD0002);
        step(); idle();
        @(negedge clk);

        // Starvation: fetch is forced through on the fifth contended cycle
        for (int k = 1; k <= 6; k++) begin
            step();
            bus.if_req = 1'b1; bus.if_addr = 16'd3;
            bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'(k % 4);
            @(negedge clk);
            $display("starve cycle %0d if_gnt=%0b dm_gnt=%0b", k, bus.if_gnt, bus.dm_gnt);
            chk("starve_if_gnt", bus.if_gnt, (k == 5));
            chk("starve_dm_gnt", bus.dm_gnt, (k != 5));
        end
        step(); idle();
        @(negedge clk);

        // Data write then read-back
        step();
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 16'd5; bus.dm_wdata = 32'h12345678;
        @(negedge clk);
        chk("wr_dm_gnt", bus.dm_gnt, 1'b1);
        chk("wr_mem_we", bus.mem_we, 1'b1);
        chk("wr_mem_addr", bus.mem_addr, 16'd5);
        step(); idle();
        @(negedge clk);
        chk("wr_no_rvalid", bus.dm_rvalid, 1'b0);
        step();
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'd5;
        @(negedge clk);
        chk("rd5_dm_gnt", bus.dm_gnt, 1'b1);
        step(); idle();
        @(negedge clk);
        $display("readback addr 5 rvalid=%0b data=%0h", bus.dm_rvalid, bus.dm_rdata);
        chk("rd5_rvalid", bus.dm_rvalid, 1'b1);
        chk("rd5_rdata", bus.dm_rdata, 32'h12345678);

        // Overflow cap on the DEPTH=4 instance
        step(); rst4 = 1'b0;
        @(negedge clk);
        chk("ovf_ready_init", b4.ld_ready, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
            b4.ld_valid = 1'b1; b4.ld_last = 1'b0; b4.ld_data = 32'h40000000 + 32'(i);
            @(negedge clk);
            $display("ovf word %0d ready=%0b mem_en=%0b addr=%0h", i, b4.ld_ready, b4.mem_en, b4.mem_addr);
            chk("ovf_ready", b4.ld_ready, (i < 4));
            chk("ovf_mem_en", b4.mem_en, (i < 4));
            if (i < 4) chk("ovf_mem_addr", b4.mem_addr, 16'(i));
        end
        step(); b4.ld_valid = 1'b0;
        @(negedge clk);
        chk("ovf_writes", 64'(w4_cnt), 64'd4);
        chk("ovf_load_count", b4.load_count, 17'd4);
        chk("ovf_load_done", b4.load_done, 1'b1);

        // Reset in the return cycle of a data read
        step();
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'd5;
        @(negedge clk);
        chk("rstrd_dm_gnt", bus.dm_gnt, 1'b1);
        step(); idle(); rst = 1'b1;
        @(negedge clk);
        chk("rstrd_no_rvalid", bus.dm_rvalid, 1'b0);
        chk("rstrd_mem_en", bus.mem_en, 1'b0);
        step(); rst = 1'b0;
        @(negedge clk);
        $display("after reset load_count=%0d load_done=%0b ld_ready=%0b",
                 bus.load_count, bus.load_done, bus.ld_ready);
        chk("rstrd_load_count", bus.load_count, 17'd0);
        chk("rstrd_load_done", bus.load_done, 1'b0);
        chk("rstrd_ld_ready0", bus.ld_ready, 1'b0);
        chk("rstrd_dm_rvalid", bus.dm_rvalid, 1'b0);
        step();
        @(negedge clk);
        chk("rstrd_ld_ready1", bus.ld_ready, 1'b1);
        chk("rstrd_mem5_kept", tb_mem[5], 32'h12345678);
        chk("rstrd_mem0_kept", tb_mem[0], 32'hDEAD0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
